weight_bram_reader: RTL
=======================

# weight_bram_reader

Read-side sequencer for the per-neuron weight BRAMs. On a start request it walks the BRAM address space from 0 to DEPTH-1, drives the BRAM's ADDR/EN/WE pins, captures the 16-bit words the BRAM returns on its negative-edge read port, and presents them to the downstream MAC as a valid/ready stream tagged with index and last flag. It sits between a weight BRAM instance and the neuron accumulator, and is instantiated once per BRAM.

## Interface
- DEPTH, 28, number of weight words to read; range 1..2^AW
- AW, 5, BRAM address width
- DW, 16, weight word width
- CLK  in  1  system clock; all state changes on rising edge; the BRAM reads on falling edge
- RST  in  1  reset, synchronous, active-high
- START  in  1  begin a read pass; sampled only in IDLE
- BUSY  out  1  high while a pass is in progress
- DONE  out  1  one-cycle pulse on the final stream handshake
- ADDR  out  AW  BRAM address, registered
- EN  out  1  BRAM enable, registered; high only in cycles that issue a read
- WE  out  1  BRAM write enable; constant 0
- DO_IN  in  DW  BRAM read data
- W_DATA  out  DW  stream weight word
- W_IDX  out  AW  address the word was read from
- W_VALID  out  1  stream valid
- W_READY  in  1  stream ready from consumer
- W_LAST  out  1  high with the word at index DEPTH-1

## Operation
- States: IDLE, FETCH, DRAIN.
  - IDLE: START=1 -> FETCH; the first read is issued on the same edge.
  - FETCH: issue reads until index DEPTH-1 has been issued, then -> DRAIN.
  - DRAIN: wait until the final word is accepted, then -> IDLE and pulse DONE.
- Output buffer: 2-entry show-ahead FIFO. W_VALID = (count != 0). W_DATA, W_IDX and W_LAST come from the head entry.
- In-flight flag INF: set on any edge that issues a read; cleared on the next edge, when DO_IN is pushed into the FIFO together with the issued index.
- Issue rule: a read is issued at an edge when addresses remain and (count + INF − pop) < 2, where pop = W_VALID & W_READY in that cycle.
  - On issue: EN <= 1, ADDR <= next index, next index increments.
  - Otherwise EN <= 0 and ADDR holds.
  - This rule guarantees the FIFO can never overflow.
- A push and a pop on the same edge leave count unchanged and keep order correct.
- The index counter must not increment past DEPTH-1; no wrap-around within a pass. Each pass restarts at 0.
- START outside IDLE is ignored: no restart and no queuing.
- WE is never asserted, so the BRAM contents are never disturbed.
- RST, including mid-pass, synchronously returns the block to IDLE. FIFO is emptied, INF cleared, index set to 0. Any in-flight BRAM data is discarded.

## Timing
- Reset values: BUSY=0, DONE=0, ADDR=0, EN=0, WE=0, W_VALID=0, W_DATA=0, W_IDX=0, W_LAST=0.
- Edge E0 samples START=1 in IDLE. After E0: EN=1, ADDR=0, BUSY=1.
- BRAM updates DO on the falling edge inside that cycle. E1 pushes DO_IN into the FIFO.
- After E1: W_VALID=1 with W_IDX=0. Start-to-first-valid latency is 2 edges.
- With W_READY held at 1, throughput is one word per cycle. Index k is valid after edge E(k+1).
- DONE is high for the cycle after the edge on which the index DEPTH-1 handshake occurs. BUSY falls on that same edge.
- Back-to-back passes: START is accepted on the edge after DONE is seen, i.e. in the first IDLE cycle.
- Under backpressure, W_DATA, W_IDX and W_LAST hold stable while W_VALID=1 and W_READY=0.
- EN stays 0 during a stall, so DO is held and no read is wasted.

## Test plan
- DEPTH=28, BRAM preloaded with word i = 16'h0100+i, START pulse, W_READY=1 -> 28 words 0x0100..0x011B in order. W_IDX 0..27, W_LAST only on idx 27. First valid 2 edges after START; DONE 1 cycle; EN high for exactly 28 cycles.
- Same setup, W_READY toggling 1,0,0,1 repeatedly -> every word delivered exactly once, in order, with no duplicates. Outputs stable during stalls. EN never high while count+INF=2 without a pop.
- START asserted again at word 10 -> ignored. Sequence continues to idx 27; a single DONE.
- RST asserted at word 15, then START -> all outputs at reset values the cycle after RST. New pass begins at W_IDX=0 with correct data.
- DEPTH=1 -> a single word with W_LAST=1, DONE after the handshake, EN high for exactly one cycle.
- START on the first IDLE cycle after DONE -> second pass identical to the first, with no gap artifacts.

Source files
------------

// File: rtl/weight_bram_reader.sv
// Read-side sequencer for a per-neuron weight BRAM: walks addresses 0..DEPTH-1 and
// streams the returned words downstream through a 2-entry show-ahead buffer.
module weight_bram_reader #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] ADDR,
  output logic          EN,
  output logic          WE,
  input  logic [DW-1:0] DO_IN,
  output logic [DW-1:0] W_DATA,
  output logic [AW-1:0] W_IDX,
  output logic          W_VALID,
  input  logic          W_READY,
  output logic          W_LAST
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [AW-1:0] next_idx_r;
  logic          more_r;
  logic [AW-1:0] addr_r;
  logic          en_r;
  logic          inf_r;
  logic [1:0]    count_r;
  logic [DW-1:0] head_data_r;
  logic [AW-1:0] head_idx_r;
  logic          head_last_r;
  logic [DW-1:0] tail_data_r;
  logic [AW-1:0] tail_idx_r;
  logic          tail_last_r;
  logic          busy_r;
  logic          done_r;

  logic          pop_s;
  logic          push_s;
  logic          push_last_s;
  logic [2:0]    occ_s;
  logic          final_pop_s;
  logic          issue_s;
  logic          start_s;
  logic [AW-1:0] issue_idx_s;

  assign pop_s       = (count_r != 2'd0) && W_READY;
  assign push_s      = inf_r;
  // The pending read lands at ADDR, which holds until the next issue.
  assign push_last_s = (addr_r == LAST_IDX);
  assign occ_s       = {1'b0, count_r} + {2'b00, inf_r} - {2'b00, pop_s};
  assign final_pop_s = pop_s && head_last_r;
  assign issue_idx_s = start_s ? {AW{1'b0}} : next_idx_r;

  // Next-state and read-issue decision.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    start_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (START) begin
          state_nxt_s = FETCH;
          issue_s     = 1'b1;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        if (!more_r) begin
          state_nxt_s = DRAIN;
        end else if (occ_s < 3'd2) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      DRAIN: begin
        if (final_pop_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Control state, BRAM address/enable and the read-in-flight flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= IDLE;
      next_idx_r <= {AW{1'b0}};
      more_r     <= 1'b0;
      addr_r     <= {AW{1'b0}};
      en_r       <= 1'b0;
      inf_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      en_r    <= issue_s;
      inf_r   <= issue_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_r == DRAIN) && final_pop_s;
      if (issue_s) begin
        addr_r <= issue_idx_s;
        if (issue_idx_s == LAST_IDX) begin
          more_r <= 1'b0;
        end else begin
          more_r     <= 1'b1;
          next_idx_r <= issue_idx_s + AW'(1);
        end
      end
    end
  end

  // Two-entry output buffer; the head slot drives the stream directly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_r     <= 2'd0;
      head_data_r <= {DW{1'b0}};
      head_idx_r  <= {AW{1'b0}};
      head_last_r <= 1'b0;
      tail_data_r <= {DW{1'b0}};
      tail_idx_r  <= {AW{1'b0}};
      tail_last_r <= 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b11: begin
          if (count_r == 2'd1) begin
            head_data_r <= DO_IN;
            head_idx_r  <= addr_r;
            head_last_r <= push_last_s;
          end else begin
            head_data_r <= tail_data_r;
            head_idx_r  <= tail_idx_r;
            head_last_r <= tail_last_r;
            tail_data_r <= DO_IN;
            tail_idx_r  <= addr_r;
            tail_last_r <= push_last_s;
          end
        end
        2'b10: begin
          if (count_r == 2'd0) begin
            head_data_r <= DO_IN;
            head_idx_r  <= addr_r;
            head_last_r <= push_last_s;
            count_r     <= 2'd1;
          end else begin
            tail_data_r <= DO_IN;
            tail_idx_r  <= addr_r;
            tail_last_r <= push_last_s;
            count_r     <= 2'd2;
          end
        end
        2'b01: begin
          head_data_r <= tail_data_r;
          head_idx_r  <= tail_idx_r;
          head_last_r <= tail_last_r;
          count_r     <= count_r - 2'd1;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign BUSY    = busy_r;
  assign DONE    = done_r;
  assign ADDR    = addr_r;
  assign EN      = en_r;
  assign WE      = 1'b0;
  assign W_DATA  = head_data_r;
  assign W_IDX   = head_idx_r;
  assign W_LAST  = head_last_r;
  assign W_VALID = (count_r != 2'd0);

endmodule
